// File: rtl/sklansky_adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered 8-bit adder among NREQ requesters.
// Optional saturation and carry-out flag: define SKLANSKY_ARB_SAT_EN.
module sklansky_adder_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic              adder_rst,
  output logic              adder_start,
  output logic [7:0]        adder_a,
  output logic [7:0]        adder_b,
  input  logic [7:0]        adder_sum,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_sum,
  output logic [2:0]        rsp_id,
  output logic              rsp_ovf,
  output logic              busy
);

  // state | meaning
  // IDLE  | arbitrate, grant one requester combinationally
  // ISSUE | adder_start high, adder registers a+b at the end of this cycle
  // CAPT  | capture adder_sum into the response register
  // RESP  | hold the response until rsp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] win;
  logic       found;
  logic       accept;
  logic [7:0] a_sel;
  logic [7:0] b_sel;

  // Prefer the lowest index above ptr, otherwise wrap to the lowest index overall.
  always_comb begin
    found = 1'b0;
    win   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (3'(i) > ptr)) begin
        found = 1'b1;
        win   = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        found = 1'b1;
        win   = 3'(i);
      end
    end
  end

  assign accept = (state == IDLE) && !adder_rst && found;

  always_comb begin
    req_ready = '0;
    a_sel     = 8'h00;
    b_sel     = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == win) begin
        req_ready[i] = accept;
        a_sel        = req_a[8*i +: 8];
        b_sel        = req_b[8*i +: 8];
      end
    end
  end

  assign busy = (state != IDLE);

`ifdef SKLANSKY_ARB_SAT_EN
  logic carry;
  // Carry-out recovered from the operand MSBs and the wrapped sum MSB.
  assign carry = (adder_a[7] & adder_b[7]) | ((adder_a[7] ^ adder_b[7]) & ~adder_sum[7]);
`else
  assign rsp_ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'(NREQ-1);
      adder_rst   <= 1'b1;
      adder_start <= 1'b0;
      adder_a     <= 8'h00;
      adder_b     <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_sum     <= 8'h00;
      rsp_id      <= 3'd0;
`ifdef SKLANSKY_ARB_SAT_EN
      rsp_ovf     <= 1'b0;
`endif
    end else begin
      adder_rst   <= 1'b0;
      adder_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            adder_a     <= a_sel;
            adder_b     <= b_sel;
            rsp_id      <= win;
            ptr         <= win;
            adder_start <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= CAPT;
        CAPT: begin
`ifdef SKLANSKY_ARB_SAT_EN
          if (carry) begin
            rsp_sum <= 8'hFF;
            rsp_ovf <= 1'b1;
          end else begin
            rsp_sum <= adder_sum;
            rsp_ovf <= 1'b0;
          end
`else
          rsp_sum <= adder_sum;
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sklansky_adder_arbiter.sv
// Self-checking bench: cycle-level transaction model of the arbiter plus directed literal checks.
module tb_sklansky_adder_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic           adder_rst, adder_start;
  logic [7:0]     adder_a, adder_b;
  logic [7:0]     adder_sum = 8'h00;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [7:0]     rsp_sum;
  logic [2:0]     rsp_id;
  logic           rsp_ovf;
  logic           busy;

  always #5 clk = ~clk;

  sklansky_adder_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .adder_rst(adder_rst), .adder_start(adder_start),
    .adder_a(adder_a), .adder_b(adder_b), .adder_sum(adder_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  // Shared adder: synchronous reset, sum registered on start.
  always @(posedge clk) begin
    if (adder_rst) adder_sum <= 8'h00;
    else if (adder_start) adder_sum <= adder_a + adder_b;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: age counts cycles since the accept edge.
  bit     m_idle = 1'b1;
  bit     m_arst = 1'b1;
  int     m_age = 0;
  int     m_ptr = N-1;
  int     m_id = 0;
  int     m_a = 0;
  int     m_b = 0;
  int     cyc = 0;
  int     acc_id[$];
  int     acc_cyc[$];
  logic [N-1:0] g;
  int     s, w;
  logic [7:0] es;
  logic   eo;

  function automatic logic [N-1:0] exp_grant(input int ptr, input logic [N-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr+k)%N]) begin
        r[(ptr+k)%N] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_adder_rst", adder_rst, 1);
      chk("rst_adder_start", adder_start, 0);
      chk("rst_adder_a", adder_a, 0);
      chk("rst_adder_b", adder_b, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_ovf", rsp_ovf, 0);
      chk("rst_busy", busy, 0);
      m_idle = 1'b1; m_arst = 1'b1; m_ptr = N-1; m_age = 0;
    end else begin
      g = (m_idle && !m_arst) ? exp_grant(m_ptr, req_valid) : '0;
      chk("req_ready", req_ready, g);
      chk("adder_rst", adder_rst, m_arst);
      chk("adder_start", adder_start, !m_idle && m_age == 1);
      chk("rsp_valid", rsp_valid, !m_idle && m_age >= 3);
      chk("busy", busy, !m_idle);
      if (!m_idle && m_age <= 2) begin
        chk("adder_a", adder_a, m_a);
        chk("adder_b", adder_b, m_b);
      end
      if (!m_idle && m_age >= 3) begin
        s = m_a + m_b;
`ifdef SKLANSKY_ARB_SAT_EN
        es = (s > 255) ? 8'hFF : 8'(s);
        eo = (s > 255);
`else
        es = 8'(s);
        eo = 1'b0;
`endif
        chk("rsp_sum", rsp_sum, es);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_ovf", rsp_ovf, eo);
      end
      if (m_arst) begin
        m_arst = 1'b0;
      end else if (m_idle) begin
        if (g != '0) begin
          w = 0;
          for (int i = 0; i < N; i++) if (g[i]) w = i;
          m_a = req_a[8*w +: 8];
          m_b = req_b[8*w +: 8];
          m_id = w; m_ptr = w; m_idle = 1'b0; m_age = 1;
          acc_id.push_back(w);
          acc_cyc.push_back(cyc);
        end
      end else if (m_age >= 3) begin
        if (rsp_ready) m_idle = 1'b1;
      end else begin
        m_age++;
      end
    end
  end

  task automatic cyc_t();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
  endtask

  // Returns 1 when requester id is granted within the budget; leaves time at cycle n+1.
  task automatic wait_grant(input int id, output bit got);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) chk("grant_timeout", 0, 1);
    else cyc_t();
  endtask

  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] esum, input logic eovf, input int hold);
    bit got;
    rsp_ready = (hold == 0);
    set_op(id, a, b);
    req_valid = '0;
    req_valid[id] = 1'b1;
    wait_grant(id, got);
    req_valid = '0;
    if (!got) return;
    chk("op_start_n1", adder_start, 1);
    cyc_t();
    chk("op_start_n2", adder_start, 0);
    chk("op_valid_n2", rsp_valid, 0);
    cyc_t();
    chk("op_valid_n3", rsp_valid, 1);
    chk("op_sum_n3", rsp_sum, esum);
    chk("op_id_n3", rsp_id, id);
    chk("op_ovf_n3", rsp_ovf, eovf);
    if (hold > 0) begin
      req_valid = '1;
      repeat (hold) begin
        cyc_t();
        chk("hold_valid", rsp_valid, 1);
        chk("hold_sum", rsp_sum, esum);
        chk("hold_id", rsp_id, id);
        chk("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      cyc_t();
      chk("release_valid_drop", rsp_valid, 0);
      req_valid = '0;
    end
    cyc_t();
  endtask

  initial begin
    bit got;
    // Reset release: grant withheld for one cycle while adder_rst is high.
    req_valid = 4'b0001;
    set_op(0, 8'h11, 8'h22);
    repeat (3) cyc_t();
    rst_n = 1'b1;
    #1;
    chk("release_adder_rst", adder_rst, 1);
    chk("release_ready", req_ready, 0);
    cyc_t();
    chk("first_adder_rst_low", adder_rst, 0);
    chk("first_grant", req_ready, 4'b0001);
    cyc_t();
    req_valid = '0;
    chk("first_busy", busy, 1);
    repeat (4) cyc_t();

    run_op(2, 8'h3C, 8'h05, 8'h41, 1'b0, 0);
`ifdef SKLANSKY_ARB_SAT_EN
    run_op(1, 8'hF0, 8'h20, 8'hFF, 1'b1, 0);
`else
    run_op(1, 8'hF0, 8'h20, 8'h10, 1'b0, 0);
`endif
    run_op(3, 8'h12, 8'h34, 8'h46, 1'b0, 10);

    // Abort in CAPT, then fairness from a fresh reset.
    set_op(1, 8'h07, 8'h09);
    req_valid = 4'b0010;
    wait_grant(1, got);
    req_valid = '0;
    cyc_t();
    chk("abort_in_capt_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_adder_rst", adder_rst, 1);
    chk("abort_adder_a", adder_a, 0);
    chk("abort_rsp_sum", rsp_sum, 0);
    for (int i = 0; i < N; i++) set_op(i, 8'(8'h10 * (i + 1)), 8'(i + 1));
    req_valid = '1;
    rsp_ready = 1'b1;
    cyc_t();
    acc_id.delete();
    acc_cyc.delete();
    cyc_t();
    rst_n = 1'b1;
    repeat (25) cyc_t();
    chk("fair_count", acc_id.size() >= 5, 1);
    if (acc_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) chk("fair_order", acc_id[k], k % N);
      for (int k = 0; k < 4; k++) chk("fair_spacing", acc_cyc[k+1] - acc_cyc[k], 4);
    end
    req_valid = '0;
    repeat (6) cyc_t();

    // Random traffic: valids may drop before grant, random backpressure.
    repeat (3000) begin
      req_valid = N'($urandom);
      req_a = ($urandom << 0);
      req_b = ($urandom << 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc_t();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) cyc_t();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sklansky_adder_arbiter.md
# sklansky_adder_arbiter

Round-robin arbiter and sequencer that shares one `sklansky_adder_8bit` instance among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the adder's `a`, `b`, `start` and `rst` inputs. It captures the registered `sum` and returns it on a single valid/ready response channel tagged with the requester index. It sits between the neuron difference/accumulate units and the shared adder.

## Interface
- `NREQ`, default 4: number of requesters, legal range 2..8.
- `clk`  in  1: the only clock; the adder runs on the same clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: requester i holds an operand pair.
- `req_ready`  out  NREQ: grant/accept strobe, one-hot or zero.
- `req_a`  in  8*NREQ: operand A of requester i, in bits [8i+7:8i].
- `req_b`  in  8*NREQ: operand B of requester i, in bits [8i+7:8i].
- `adder_rst`  out  1: drives the adder's synchronous active-high `rst`.
- `adder_start`  out  1: drives the adder's `start`.
- `adder_a`  out  8: drives the adder's `a`.
- `adder_b`  out  8: drives the adder's `b`.
- `adder_sum`  in  8: the adder's registered `sum`.
- `rsp_valid`  out  1: a result is available.
- `rsp_ready`  in  1: the consumer accepts the result.
- `rsp_sum`  out  8: the result value.
- `rsp_id`  out  3: index of the requester that owns the result.
- `rsp_ovf`  out  1: unsigned carry-out flag (see Configuration).
- `busy`  out  1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE:
  - Winner = first i with `req_valid[i]`, searching from `ptr+1` upward and wrapping modulo NREQ.
  - `req_ready[winner]` = 1, applied combinationally. All other `req_ready` bits are 0.
  - `req_ready` is 0 in every other state.
- Accept (IDLE and `req_valid[w] & req_ready[w]`):
  - Latch `adder_a`/`adder_b` from slice w and set `rsp_id`=w.
  - Set `ptr`=w and go to ISSUE.
- ISSUE: `adder_start`=1; go to CAPT.
- CAPT:
  - `rsp_sum` <= `adder_sum`; `rsp_valid` <= 1.
  - `rsp_ovf` <= carry (when enabled); go to RESP.
- RESP:
  - `rsp_valid`, `rsp_sum`, `rsp_id` and `rsp_ovf` are held stable.
  - On `rsp_ready`: `rsp_valid` <= 0; go to IDLE.
- `adder_a`/`adder_b` are held from accept through the end of CAPT.
- `adder_start` is 0 in every state except ISSUE.
- A requester may drop `req_valid` before it is granted. This has no effect; it is simply skipped.
- Arithmetic is modulo 2^8; `rsp_sum` = (a+b) mod 256.
- Carry = `a[7]&b[7] | (a[7]^b[7])&~adder_sum[7]`, computed from the held operands.
- `adder_rst` is a register: reset value 1, cleared on the first clock after `rst_n` deasserts. While it is 1, the FSM stays in IDLE and `req_ready`=0.

## Timing
- Reset values:
  - `ptr`=NREQ-1, so requester 0 has first priority.
  - State IDLE; `adder_rst`=1.
  - `adder_start`, `adder_a`, `adder_b`, `rsp_valid`, `rsp_sum`, `rsp_id`, `rsp_ovf`, `busy` all 0.
- Cycle sequence, with the accept edge at the end of cycle n:
  - Cycle n+1: ISSUE.
  - End of cycle n+1: the adder registers the sum.
  - Cycle n+2: CAPT.
  - Cycle n+3: `rsp_valid`=1 (first possible cycle).
- With `rsp_ready` held at 1, the next accept is possible in cycle n+4. Peak throughput is one operation per 4 cycles.
- Asserting `rst_n` low mid-operation aborts immediately: the in-flight operation is lost and all outputs take their reset values asynchronously.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0…
- A requester waits at most NREQ-1 other grants.

## Configuration
- `SKLANSKY_ARB_SAT_EN` defined:
  - In CAPT, if carry=1, then `rsp_sum`<=8'hFF and `rsp_ovf`<=1.
  - Otherwise `rsp_sum`<=`adder_sum` and `rsp_ovf`<=0.
- `SKLANSKY_ARB_SAT_EN` undefined:
  - `rsp_sum`<=`adder_sum` (wraps).
  - `rsp_ovf` is tied to 0 and no carry logic is built.

## Test plan
- Reset release:
  - `adder_rst`=1 for the first cycle and `req_ready`=0 even with `req_valid[0]`=1.
  - Grant to requester 0 follows in the next cycle.
- Single op, requester 2 with a=8'h3C, b=8'h05:
  - `adder_start` is high exactly one cycle.
  - `rsp_valid` is asserted 3 cycles after accept with `rsp_sum`=8'h41, `rsp_id`=2.
- All 4 requesters valid, `rsp_ready`=1:
  - Accept order 0,1,2,3,0.
  - Accepts 4 cycles apart.
  - Each `rsp_sum` matches its own slice.
- Backpressure:
  - Hold `rsp_ready`=0 for 10 cycles: `rsp_valid`/`rsp_sum`/`rsp_id` stay stable and all `req_ready`=0.
  - Release: `rsp_valid` drops one cycle later.
- Overflow, a=8'hF0, b=8'h20:
  - Macro undefined: `rsp_sum`=8'h10, `rsp_ovf`=0.
  - Macro defined: `rsp_sum`=8'hFF, `rsp_ovf`=1.
- Assert `rst_n` low during CAPT:
  - All outputs return to reset values immediately.
  - No `rsp_valid` pulse.
  - After release, requester 0 is granted first.
